fpu_cmp_responder: RTL and testbench
====================================

Name: fpu_cmp_responder

Overview:
- Synthesizable FPU-side responder for the FPU issue protocol: accepts decode/execute/flush from an issuing agent and returns single-precision compare results with a valid strobe.
- Serves as the known-good responder for self-checking the stimulus side of the FPU bench. It also serves as a drop-in compare unit alongside the arithmetic DUV.
- Implements the IEEE-754 compare subset: equal, not-equal, greater, greater-or-equal, less, less-or-equal. Result latency is programmable.

Parameters:
- LATENCY, 2, cycles from the execute pulse to valid_compare; legal range 1..15.
- OP_W, 8, width of fpu_op (matches OR1K_FPUOP_WIDTH).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  abort the current op and clear the outputs
- decode  in  1  capture pulse for operands and opcode
- execute  in  1  start pulse
- fpu_op  in  OP_W  opcode; bit3=1 marks a compare, bits[2:0] select the function
- opA  in  32  operand A, IEEE single
- opB  in  32  operand B, IEEE single
- compare  out  1  compare result flag
- valid_compare  out  1  result valid, held until cleared
- inv_flag  out  1  invalid-operation flag (sNaN operand)
- busy  out  1  op in flight (DECODED or BUSY)

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0, FSM in IDLE, latency counter 0. Reset mid-op drops the op silently.
- States:
  - IDLE: decode moves to DECODED and registers fpu_op, opA and opB.
  - DECODED: execute loads counter=LATENCY-1 and moves to BUSY. A second decode re-captures the inputs and stays in DECODED.
  - BUSY: counter decrements each cycle. At 0, the FSM registers compare and inv_flag, sets valid_compare=1 and moves to DONE. Inputs that change during BUSY are ignored (operands already latched).
  - DONE: outputs held. decode clears valid_compare/compare/inv_flag and moves to DECODED. execute without decode is ignored.
- Latency: execute sampled high at edge N gives valid_compare=1 after edge N+LATENCY. With LATENCY=1, valid is visible the cycle after execute.
- flush has priority over decode and execute in every state. The next edge forces IDLE and clears compare, valid_compare, inv_flag and busy. flush together with decode: flush wins and nothing is captured.
- execute in IDLE is ignored. decode and execute high in the same cycle from IDLE: decode is taken, execute is ignored.
- Compare codes (bits[2:0]):
  - 0=eq, 1=ne, 2=gt, 3=ge, 4=lt, 5=le.
  - 6, 7 and any op with bit3=0: illegal. Illegal ops complete normally with compare=0, inv_flag=0.
- Compare rules:
  - +0 equals -0.
  - Magnitude ordering uses sign plus bits[30:0].
  - For negatives, a larger magnitude is smaller.
  - Denormals compare by raw bits (no flushing).
- NaN (exp=FF, frac≠0): every compare is false except ne, which is true.
- inv_flag=1 when:
  - either operand is an sNaN (frac[22]=0), for any compare; or
  - either operand is a qNaN, for gt/ge/lt/le.

Optional Feature:
- Macro: FPU_CMP_UNORDERED_EN.
- Defined: code 6 = unordered (true iff either operand is NaN) and code 7 = ordered (true iff neither is NaN). inv_flag is set only for sNaN on these two codes.
- Undefined: codes 6/7 stay illegal (compare=0, inv_flag=0, valid still asserted). No extra logic is synthesized.

Test Plan:
- LATENCY=2, opA=0x3F800000 (1.0), opB=0x40000000 (2.0), op=0x0C (lt): decode, then execute at edge N -> valid_compare=1 and compare=1 after edge N+2; inv_flag=0.
- opA=0x00000000, opB=0x80000000, op=0x08 (eq) -> compare=1. Same operands with op=0x0A (gt) -> compare=0.
- opA=0x7FC00000 (qNaN), opB=0x3F800000:
  - op=0x09 (ne) -> compare=1, inv_flag=0.
  - op=0x0B (ge) -> compare=0, inv_flag=1.
  - opA=0x7F800001 (sNaN) with op=0x08 -> compare=0, inv_flag=1.
- opA=0xC0000000 (-2.0), opB=0xBF800000 (-1.0), op=0x0D (le) -> compare=1. op=0x0A (gt) -> compare=0.
- flush asserted one cycle after execute (BUSY) -> next edge: busy=0, valid_compare stays 0 for the next 5 cycles. A following decode/execute completes normally.
- reset_n pulsed low while in DONE -> valid_compare, compare and inv_flag drop to 0 asynchronously, without waiting for clk. With FPU_CMP_UNORDERED_EN defined, op=0x0E on qNaN/1.0 -> compare=1. Without the macro -> compare=0.

Source files
------------

// File: rtl/fpu_cmp_responder_if.sv
// FPU issue/response bundle between an issuing agent (master) and the
// compare responder (slave). Clock and reset are kept as plain ports.
interface fpu_cmp_responder_if #(
   parameter int OP_W = 8
);
   logic            flush;
   logic            decode;
   logic            execute;
   logic [OP_W-1:0] fpu_op;
   logic [31:0]     opA;
   logic [31:0]     opB;
   logic            compare;
   logic            valid_compare;
   logic            inv_flag;
   logic            busy;

   modport master (
      output flush, decode, execute, fpu_op, opA, opB,
      input  compare, valid_compare, inv_flag, busy
   );

   modport slave (
      input  flush, decode, execute, fpu_op, opA, opB,
      output compare, valid_compare, inv_flag, busy
   );
endinterface

// File: rtl/fpu_cmp_responder.sv
// Single-precision compare responder for the FPU issue protocol.
// decode captures opcode/operands, execute starts a fixed-latency countdown,
// and the registered result is presented with valid_compare until the next
// decode, flush or reset. flush beats decode/execute in every state.
// Optional build macro: FPU_CMP_UNORDERED_EN enables codes 6 (unordered)
// and 7 (ordered); without it those codes complete as illegal ops.
module fpu_cmp_responder #(
   parameter int LATENCY = 2,
   parameter int OP_W    = 8
) (
   input logic                clk,
   input logic                reset_n,
   fpu_cmp_responder_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DECODED = 2'd1,
      ST_BUSY    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [3:0]  cnt_r;
   logic [3:0]  cnt_nxt_s;
   logic        capture_s;
   logic        clear_s;
   logic        finish_s;
   logic [3:0]  op_r;
   logic [31:0] opa_r;
   logic [31:0] opb_r;
   logic [1:0]  result_s;
   logic        compare_r;
   logic        valid_r;
   logic        inv_r;
   logic        busy_r;
   logic        op_unused_s;

   // Opcode bits above the compare marker carry no meaning for this unit.
   assign op_unused_s = ^bus.fpu_op[OP_W-1:4];

   // Evaluates one compare; returns {compare, inv_flag}.
   function automatic logic [1:0] cmp_eval(
      input logic [3:0]  op,
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic a_nan;
      logic b_nan;
      logic any_nan;
      logic any_snan;
      logic zeros;
      logic eq;
      logic lt;
      logic gt;
      logic res;
      logic inv;
      a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      any_nan  = a_nan || b_nan;
      any_snan = (a_nan && !a[22]) || (b_nan && !b[22]);
      // +0 and -0 are the same value regardless of sign.
      zeros    = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
      eq       = !any_nan && (zeros || (a == b));
      if (any_nan || zeros) begin
         lt = 1'b0;
      end else if (a[31] != b[31]) begin
         lt = a[31];
      end else if (a[31]) begin
         // Both negative: the larger magnitude is the smaller value.
         lt = (a[30:0] > b[30:0]);
      end else begin
         lt = (a[30:0] < b[30:0]);
      end
      gt  = !any_nan && !eq && !lt;
      res = 1'b0;
      inv = 1'b0;
      if (op[3]) begin
         case (op[2:0])
            3'd0: begin res = eq;        inv = any_snan;            end
            3'd1: begin res = !eq;       inv = any_snan;            end
            3'd2: begin res = gt;        inv = any_snan || any_nan; end
            3'd3: begin res = gt || eq;  inv = any_snan || any_nan; end
            3'd4: begin res = lt;        inv = any_snan || any_nan; end
            3'd5: begin res = lt || eq;  inv = any_snan || any_nan; end
`ifdef FPU_CMP_UNORDERED_EN
            3'd6: begin res = any_nan;   inv = any_snan;            end
            3'd7: begin res = !any_nan;  inv = any_snan;            end
`endif
            default: begin res = 1'b0;   inv = 1'b0;                end
         endcase
      end else begin
         res = 1'b0;
         inv = 1'b0;
      end
      return {res, inv};
   endfunction

   assign result_s = cmp_eval(op_r, opa_r, opb_r);

   // State and latency counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state logic; flush takes precedence over every other request.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      capture_s   = 1'b0;
      clear_s     = 1'b0;
      finish_s    = 1'b0;
      if (bus.flush) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = 4'd0;
         clear_s     = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.decode) begin
                  state_nxt_s = ST_DECODED;
                  capture_s   = 1'b1;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_DECODED: begin
               if (bus.decode) begin
                  state_nxt_s = ST_DECODED;
                  capture_s   = 1'b1;
               end else if (bus.execute) begin
                  state_nxt_s = ST_BUSY;
                  cnt_nxt_s   = CNT_LOAD;
               end else begin
                  state_nxt_s = ST_DECODED;
               end
            end
            ST_BUSY: begin
               if (cnt_r == 4'd0) begin
                  state_nxt_s = ST_DONE;
                  finish_s    = 1'b1;
               end else begin
                  cnt_nxt_s   = cnt_r - 4'd1;
               end
            end
            ST_DONE: begin
               if (bus.decode) begin
                  state_nxt_s = ST_DECODED;
                  capture_s   = 1'b1;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 4'd0;
               clear_s     = 1'b1;
            end
         endcase
      end
   end

   // Operand/opcode capture; held through BUSY so late input changes are ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_r  <= 4'd0;
         opa_r <= 32'd0;
         opb_r <= 32'd0;
      end else if (capture_s) begin
         op_r  <= bus.fpu_op[3:0];
         opa_r <= bus.opA;
         opb_r <= bus.opB;
      end else begin
         op_r  <= op_r;
         opa_r <= opa_r;
         opb_r <= opb_r;
      end
   end

   // Registered result and status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         compare_r <= 1'b0;
         valid_r   <= 1'b0;
         inv_r     <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s == ST_DECODED) || (state_nxt_s == ST_BUSY);
         if (clear_s || capture_s) begin
            compare_r <= 1'b0;
            valid_r   <= 1'b0;
            inv_r     <= 1'b0;
         end else if (finish_s) begin
            compare_r <= result_s[1];
            valid_r   <= 1'b1;
            inv_r     <= result_s[0];
         end else begin
            compare_r <= compare_r;
            valid_r   <= valid_r;
            inv_r     <= inv_r;
         end
      end
   end

   assign bus.compare       = compare_r;
   assign bus.valid_compare = valid_r;
   assign bus.inv_flag      = inv_r;
   assign bus.busy          = busy_r;

endmodule

// File: tb/tb_fpu_cmp_responder.sv
// Directed-vector bench for fpu_cmp_responder with hand-computed expectations.
module tb_fpu_cmp_responder;

   localparam int LAT  = 2;
   localparam int OP_W = 8;

   logic clk;
   logic reset_n;
   int   checks;
   int   failures;

   fpu_cmp_responder_if #(.OP_W(OP_W)) bus ();

   fpu_cmp_responder #(.LATENCY(LAT), .OP_W(OP_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // decode, execute, scramble inputs during BUSY, then check latency and result.
   task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_c, input logic exp_i);
      bus.decode = 1'b1;
      bus.fpu_op = op;
      bus.opA    = a;
      bus.opB    = b;
      tick();
      bus.decode = 1'b0;
      check_eq({tag, " busy_decoded"}, 32'(bus.busy), 32'd1);
      bus.execute = 1'b1;
      tick();
      bus.execute = 1'b0;
      bus.opA     = ~a;
      bus.opB     = 32'h0000_0000;
      bus.fpu_op  = 8'h00;
      for (int i = 0; i < LAT; i++) begin
         check_eq({tag, " valid_early"}, 32'(bus.valid_compare), 32'd0);
         tick();
      end
      check_eq({tag, " valid"},   32'(bus.valid_compare), 32'd1);
      check_eq({tag, " compare"}, 32'(bus.compare),       32'(exp_c));
      check_eq({tag, " inv"},     32'(bus.inv_flag),      32'(exp_i));
      check_eq({tag, " busy_done"}, 32'(bus.busy),        32'd0);
   endtask

   initial begin
      logic exp_unord;
      checks      = 0;
      failures    = 0;
      reset_n     = 1'b0;
      bus.flush   = 1'b0;
      bus.decode  = 1'b0;
      bus.execute = 1'b0;
      bus.fpu_op  = 8'h00;
      bus.opA     = 32'h0;
      bus.opB     = 32'h0;
      repeat (2) tick();
      check_eq("rst compare", 32'(bus.compare),       32'd0);
      check_eq("rst valid",   32'(bus.valid_compare), 32'd0);
      check_eq("rst inv",     32'(bus.inv_flag),      32'd0);
      check_eq("rst busy",    32'(bus.busy),          32'd0);
      reset_n = 1'b1;
      tick();

      // execute in IDLE is ignored
      bus.execute = 1'b1;
      tick();
      bus.execute = 1'b0;
      check_eq("idle_exec busy", 32'(bus.busy), 32'd0);
      repeat (3) tick();
      check_eq("idle_exec valid", 32'(bus.valid_compare), 32'd0);

      // flush with decode: nothing captured
      bus.flush  = 1'b1;
      bus.decode = 1'b1;
      tick();
      bus.flush  = 1'b0;
      bus.decode = 1'b0;
      check_eq("flush_dec busy", 32'(bus.busy), 32'd0);

      // decode+execute together from IDLE: decode taken, execute dropped
      bus.decode  = 1'b1;
      bus.execute = 1'b1;
      bus.fpu_op  = 8'h0C;
      bus.opA     = 32'h3F80_0000;
      bus.opB     = 32'h4000_0000;
      tick();
      bus.decode  = 1'b0;
      bus.execute = 1'b0;
      check_eq("dec_exec busy", 32'(bus.busy), 32'd1);
      repeat (LAT + 1) tick();
      check_eq("dec_exec no_valid", 32'(bus.valid_compare), 32'd0);
      bus.execute = 1'b1;
      tick();
      bus.execute = 1'b0;
      repeat (LAT) tick();
      check_eq("dec_exec valid",   32'(bus.valid_compare), 32'd1);
      check_eq("dec_exec compare", 32'(bus.compare),       32'd1);

      run_op("lt_1_2",      8'h0C, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0);
      run_op("eq_pz_nz",    8'h08, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
      run_op("gt_pz_nz",    8'h0A, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
      run_op("ge_nz_pz",    8'h0B, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0);
      run_op("ne_qnan",     8'h09, 32'h7FC0_0000, 32'h3F80_0000, 1'b1, 1'b0);
      run_op("ge_qnan",     8'h0B, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 1'b1);
      run_op("eq_snan",     8'h08, 32'h7F80_0001, 32'h3F80_0000, 1'b0, 1'b1);
      run_op("eq_qnan",     8'h08, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
      run_op("le_m2_m1",    8'h0D, 32'hC000_0000, 32'hBF80_0000, 1'b1, 1'b0);
      run_op("gt_m2_m1",    8'h0A, 32'hC000_0000, 32'hBF80_0000, 1'b0, 1'b0);
      run_op("gt_2_1",      8'h0A, 32'h4000_0000, 32'h3F80_0000, 1'b1, 1'b0);
      run_op("lt_denorm",   8'h0C, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0);
      run_op("lt_neg_pos",  8'h0C, 32'hBF80_0000, 32'h3F80_0000, 1'b1, 1'b0);
      run_op("illegal_b3",  8'h04, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0);

      // flush one cycle after execute
      bus.decode = 1'b1;
      bus.fpu_op = 8'h0C;
      bus.opA    = 32'h3F80_0000;
      bus.opB    = 32'h4000_0000;
      tick();
      bus.decode  = 1'b0;
      bus.execute = 1'b1;
      tick();
      bus.execute = 1'b0;
      bus.flush   = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_eq("flush busy",  32'(bus.busy),          32'd0);
      check_eq("flush valid", 32'(bus.valid_compare), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check_eq("flush valid_hold", 32'(bus.valid_compare), 32'd0);
      end
      run_op("after_flush", 8'h0C, 32'h3F80_0000, 32'h4000_0000, 1'b1, 1'b0);

      // asynchronous reset while in DONE
      run_op("ne_snan", 8'h09, 32'h7F80_0001, 32'h3F80_0000, 1'b1, 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("arst valid",   32'(bus.valid_compare), 32'd0);
      check_eq("arst compare", 32'(bus.compare),       32'd0);
      check_eq("arst inv",     32'(bus.inv_flag),      32'd0);
      reset_n = 1'b1;
      tick();

`ifdef FPU_CMP_UNORDERED_EN
      exp_unord = 1'b1;
`else
      exp_unord = 1'b0;
`endif
      run_op("unord_qnan", 8'h0E, 32'h7FC0_0000, 32'h3F80_0000, exp_unord, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
